// File: rtl/kugelblitz_patch_sched.sv
// kugelblitz_patch_sched
// Round-robin update scheduler for the single byte-patch rule slot. New rules
// are parked in a shadow register and only committed between frames, so a
// frame never sees a mix of old and new rules. Also drives the per-beat hit
// strobe and keeps frame / patched-frame statistics.
module kugelblitz_patch_sched #(
  parameter int KEEP_WIDTH   = 64,
  parameter int OFFSET_WIDTH = $clog2(KEEP_WIDTH),
  parameter int BEAT_WIDTH   = 8,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [1:0]                req_enable,
  input  logic [2*OFFSET_WIDTH-1:0] req_offset,
  input  logic [2*BEAT_WIDTH-1:0]   req_beat,
  input  logic [15:0]               req_data,
  input  logic                      mon_tvalid,
  input  logic                      mon_tready,
  input  logic                      mon_tlast,
  output logic                      patch_active,
  output logic [OFFSET_WIDTH-1:0]   patch_offset,
  output logic [7:0]                patch_data,
  output logic                      patch_hit,
  output logic                      pending,
  output logic [COUNT_WIDTH-1:0]    frame_count,
  output logic [COUNT_WIDTH-1:0]    patched_count
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  localparam logic [BEAT_WIDTH-1:0]  BEAT_ZERO = {BEAT_WIDTH{1'b0}};
  localparam logic [BEAT_WIDTH-1:0]  BEAT_ONE  = {{(BEAT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BEAT_WIDTH-1:0]  BEAT_MAX  = {BEAT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  logic                    rr_q;
  logic                    sh_en_q;
  logic [OFFSET_WIDTH-1:0] sh_off_q;
  logic [BEAT_WIDTH-1:0]   sh_beat_q;
  logic [7:0]              sh_data_q;
  logic                    act_en_q;
  logic [OFFSET_WIDTH-1:0] act_off_q;
  logic [BEAT_WIDTH-1:0]   act_beat_q;
  logic [7:0]              act_data_q;
  logic [BEAT_WIDTH-1:0]   beat_cnt_q;
  logic                    hit_seen_q;
  logic [COUNT_WIDTH-1:0]  frame_cnt_q;
  logic [COUNT_WIDTH-1:0]  patched_cnt_q;

  logic gnt_idx_s;
  logic gnt_valid_s;
  logic accept_s;
  logic commit_s;
  logic acc_beat_s;
  logic hit_s;

  assign acc_beat_s = mon_tvalid & mon_tready;
  assign hit_s      = act_en_q & mon_tvalid & (beat_cnt_q == act_beat_q);

  // Round-robin grant: the pointed-to requester wins, otherwise the other one.
  always_comb begin
    gnt_idx_s   = rr_q;
    gnt_valid_s = 1'b0;
    if (req_valid[rr_q]) begin
      gnt_idx_s   = rr_q;
      gnt_valid_s = 1'b1;
    end else if (req_valid[~rr_q]) begin
      gnt_idx_s   = ~rr_q;
      gnt_valid_s = 1'b1;
    end else begin
      gnt_idx_s   = rr_q;
      gnt_valid_s = 1'b0;
    end
  end

  assign req_ready[0] = (state_q == ST_IDLE) & gnt_valid_s & ~gnt_idx_s;
  assign req_ready[1] = (state_q == ST_IDLE) & gnt_valid_s &  gnt_idx_s;

  // Next-state logic: accept one request, then hold it until a frame boundary.
  always_comb begin
    state_d  = state_q;
    accept_s = 1'b0;
    commit_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid_s) begin
          accept_s = 1'b1;
          state_d  = ST_PENDING;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_PENDING: begin
        // A first beat starting a multi-beat frame keeps the old rule.
        if (((beat_cnt_q == BEAT_ZERO) & ~acc_beat_s) | (acc_beat_s & mon_tlast)) begin
          commit_s = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d  = ST_PENDING;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the granted request into the shadow slot and advance the pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q      <= 1'b0;
      sh_en_q   <= 1'b0;
      sh_off_q  <= {OFFSET_WIDTH{1'b0}};
      sh_beat_q <= BEAT_ZERO;
      sh_data_q <= 8'h00;
    end else if (accept_s) begin
      rr_q      <= ~gnt_idx_s;
      sh_en_q   <= req_enable[gnt_idx_s];
      sh_off_q  <= gnt_idx_s ? req_offset[2*OFFSET_WIDTH-1:OFFSET_WIDTH] : req_offset[OFFSET_WIDTH-1:0];
      sh_beat_q <= gnt_idx_s ? req_beat[2*BEAT_WIDTH-1:BEAT_WIDTH] : req_beat[BEAT_WIDTH-1:0];
      sh_data_q <= gnt_idx_s ? req_data[15:8] : req_data[7:0];
    end
  end

  // Move the shadow rule into the active slot at a frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_en_q   <= 1'b0;
      act_off_q  <= {OFFSET_WIDTH{1'b0}};
      act_beat_q <= BEAT_ZERO;
      act_data_q <= 8'h00;
    end else if (commit_s) begin
      act_en_q   <= sh_en_q;
      act_off_q  <= sh_off_q;
      act_beat_q <= sh_beat_q;
      act_data_q <= sh_data_q;
    end
  end

  // Track beat position within the frame and whether the frame was patched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= BEAT_ZERO;
      hit_seen_q <= 1'b0;
    end else if (acc_beat_s) begin
      if (mon_tlast) begin
        beat_cnt_q <= BEAT_ZERO;
        hit_seen_q <= 1'b0;
      end else begin
        if (beat_cnt_q != BEAT_MAX) begin
          beat_cnt_q <= beat_cnt_q + BEAT_ONE;
        end
        if (hit_s) begin
          hit_seen_q <= 1'b1;
        end
      end
    end
  end

  // Frame statistics, updated on each accepted end-of-frame beat; both wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q   <= {COUNT_WIDTH{1'b0}};
      patched_cnt_q <= {COUNT_WIDTH{1'b0}};
    end else if (acc_beat_s & mon_tlast) begin
      frame_cnt_q <= frame_cnt_q + CNT_ONE;
      if (hit_seen_q | hit_s) begin
        patched_cnt_q <= patched_cnt_q + CNT_ONE;
      end
    end
  end

  assign patch_active  = act_en_q;
  assign patch_offset  = act_off_q;
  assign patch_data    = act_data_q;
  assign patch_hit     = hit_s;
  assign pending       = (state_q == ST_PENDING);
  assign frame_count   = frame_cnt_q;
  assign patched_count = patched_cnt_q;

endmodule
